// File: rtl/pio_pkg.sv
// Shared constants, FSM state type and next-address helper for the PIO
// instruction fetch sequencer.
package pio_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;
  localparam int DLY_LSB = 8;
  localparam int DLY_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DELAY = 2'd2
  } state_t;

  // Program counter advance: wrap back to the bottom after the top address.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] wrap_top,
    input logic [ADDR_W-1:0] wrap_bottom
  );
    return (a == wrap_top) ? wrap_bottom : a + 1'b1;
  endfunction

endpackage

// File: rtl/pio_instr_fetch.sv
// Read-side sequencer for the PIO instruction register file: owns the program
// counter and issues one registered instruction per cycle to the execute unit.
module pio_instr_fetch
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  input  logic [ADDR_W-1:0]  wrap_bottom,
  input  logic [ADDR_W-1:0]  wrap_top,
  output logic [ADDR_W-1:0]  read_addr,
  input  logic [INSTR_W-1:0] read_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DLY_W-1:0]  dly;
  logic              complete;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_next;

  assign complete   = (state == RUN) && !stall;
  assign fetch_addr = (complete && jump_en) ? jump_addr : pc;
  assign fetch_next = next_addr(fetch_addr, wrap_top, wrap_bottom);
  assign read_addr  = fetch_addr;
  assign dly        = instr[DLY_LSB +: DLY_W];

  // Restart outranks enable, which outranks all stall/jump/delay handling.
  // NOTE: every register below is written with <= so all of them sample the
  // same pre-edge values of fetch_addr/dly; blocking writes would reorder that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      dly_cnt     <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else if (restart) begin
      state       <= IDLE;
      pc          <= wrap_bottom;
      dly_cnt     <= '0;
      instr_valid <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= RUN;
          instr       <= read_data;
          instr_pc    <= fetch_addr;
          pc          <= fetch_next;
          instr_valid <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            if (dly == '0) begin
              instr       <= read_data;
              instr_pc    <= fetch_addr;
              pc          <= fetch_next;
              instr_valid <= 1'b1;
            end else begin
              // Park the pending target in pc; it is fetched when the delay ends.
              state       <= DELAY;
              pc          <= fetch_addr;
              dly_cnt     <= dly;
              instr_valid <= 1'b0;
            end
          end
        end
        DELAY: begin
          dly_cnt <= dly_cnt - 1'b1;
          if (dly_cnt <= DLY_W'(1)) begin
            state       <= RUN;
            dly_cnt     <= '0;
            instr       <= read_data;
            instr_pc    <= fetch_addr;
            pc          <= fetch_next;
            instr_valid <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          dly_cnt     <= '0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_instr_fetch.sv
// Self-checking bench for pio_instr_fetch: directed scenarios plus randomized
// traffic compared against a behavioural sequencer model.
module tb_pio_instr_fetch;
  import pio_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               restart;
  logic [ADDR_W-1:0]  wrap_bottom;
  logic [ADDR_W-1:0]  wrap_top;
  logic [ADDR_W-1:0]  read_addr;
  logic [INSTR_W-1:0] read_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  instr_pc;
  logic               stall;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;

  logic [INSTR_W-1:0] mem [32];
  assign read_data = mem[read_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: architectural pc, the live instruction, and bubbles left.
  bit       m_valid;
  int       m_pc;
  int       m_ipc;
  int       m_bubbles;
  bit [15:0] m_instr;

  pio_instr_fetch dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .wrap_bottom(wrap_bottom), .wrap_top(wrap_top),
    .read_addr(read_addr), .read_data(read_data),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_fetch(input int a);
    m_instr = mem[a];
    m_ipc   = a;
    m_pc    = (a == int'(wrap_top)) ? int'(wrap_bottom) : (a + 1) % 32;
    m_valid = 1'b1;
    m_bubbles = 0;
  endtask

  // Inputs are already set; predict the edge, take it, compare.
  task automatic step();
    int fa;
    int d;
    #1;
    fa = (m_valid && !stall && jump_en) ? int'(jump_addr) : m_pc;
    check("read_addr", 32'(read_addr), 32'(fa));
    if (restart) begin
      m_pc = int'(wrap_bottom); m_valid = 0; m_bubbles = 0;
    end else if (!en) begin
      m_valid = 0; m_bubbles = 0;
    end else if (m_valid) begin
      if (!stall) begin
        d = int'(m_instr[12:8]);
        if (d == 0) m_fetch(fa);
        else begin
          m_pc = fa; m_bubbles = d; m_valid = 0;
        end
      end
    end else if (m_bubbles > 1) begin
      m_bubbles--;
    end else begin
      m_fetch(m_pc);
    end
    @(posedge clk);
    #1;
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr_pc", 32'(instr_pc), 32'(m_ipc));
    check("instr", 32'(instr), 32'(m_instr));
  endtask

  task automatic m_reset();
    m_valid = 0; m_pc = 0; m_ipc = 0; m_bubbles = 0; m_instr = '0;
  endtask

  task automatic do_reset();
    en = 0; restart = 0; stall = 0; jump_en = 0; jump_addr = '0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
  endtask

  task automatic load_linear();
    for (int i = 0; i < 32; i++) mem[i] = 16'(i) | 16'hA000;
  endtask

  initial begin
    int exp_seq[7];
    int exp_v[5];
    exp_seq = '{0, 1, 2, 3, 1, 2, 3};
    exp_v   = '{1, 0, 0, 0, 1};
    load_linear();
    wrap_bottom = 5'd0; wrap_top = 5'd31;
    do_reset();
    check("rst_read_addr", 32'(read_addr), 32'd0);

    // Wrap window 1..3.
    wrap_bottom = 5'd1; wrap_top = 5'd3; en = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("wrap_seq", 32'(instr_pc), 32'(exp_seq[i]));
    end

    // Jump from pc2 to 7 with no bubble.
    wrap_bottom = 5'd0; wrap_top = 5'd31;
    do_reset(); en = 1;
    step(); step(); step();
    check("pre_jump_pc", 32'(instr_pc), 32'd2);
    jump_en = 1; jump_addr = 5'd7;
    step();
    check("jump_pc", 32'(instr_pc), 32'd7);
    check("jump_valid", 32'(instr_valid), 32'd1);
    jump_en = 0;

    // Delay field 3 on pc0.
    mem[0] = 16'h0300;
    do_reset(); en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("delay_valid", 32'(instr_valid), 32'(exp_v[i]));
    end
    check("delay_next_pc", 32'(instr_pc), 32'd1);

    // Stall held four cycles on pc1.
    mem[0] = 16'h0000;
    do_reset(); en = 1;
    step(); step();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc", 32'(instr_pc), 32'd1);
      check("stall_instr", 32'(instr), 32'(mem[1]));
    end
    stall = 0;
    step();
    check("post_stall_pc", 32'(instr_pc), 32'd2);

    // Restart while in DELAY.
    mem[0] = 16'h0300; wrap_bottom = 5'd5;
    do_reset(); en = 1;
    step(); step();
    restart = 1;
    step();
    check("restart_valid", 32'(instr_valid), 32'd0);
    restart = 0;
    step();
    check("restart_pc", 32'(instr_pc), 32'd5);
    check("restart_resume", 32'(instr_valid), 32'd1);

    // Asynchronous reset mid-DELAY.
    wrap_bottom = 5'd0;
    do_reset(); en = 1;
    step(); step();
    rst = 1'b1;
    m_reset();
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_pc", 32'(instr_pc), 32'd0);
    check("arst_instr", 32'(instr), 32'd0);
    check("arst_read_addr", 32'(read_addr), 32'd0);
    #1;
    rst = 1'b0;
    step();
    check("arst_resume_pc", 32'(instr_pc), 32'd0);
    check("arst_resume_valid", 32'(instr_valid), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 32; i++)
      mem[i] = 16'($urandom) & 16'hE0FF;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en        = ($urandom % 16) != 0;
      restart   = ($urandom % 40) == 0;
      stall     = ($urandom % 4) == 0;
      jump_en   = ($urandom % 5) == 0;
      jump_addr = 5'($urandom);
      if (($urandom % 64) == 0) begin
        wrap_bottom = 5'($urandom);
        wrap_top    = 5'($urandom);
      end
      if (($urandom % 6) == 0) begin
        int a;
        logic [15:0] w;
        a = int'($urandom % 32);
        w = 16'($urandom) & 16'hE0FF;
        if (($urandom % 4) == 0) w[12:8] = 5'($urandom_range(1, 3));
        mem[a] = w;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
